// File: rtl/imm_ext_unit.sv
// Registered immediate extender for the decode path: zero/sign extension per imm_src, one-cycle latency.
// Define IMM_EXT_PREFIX_EN to build the PREFIX mechanism that supplies the upper bits of short immediates.
module imm_ext_unit #(
  parameter int DATA_W  = 22,
  parameter int IMM_W   = 19,
  parameter int SHORT_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        imm_src,
  input  logic              prefix_load,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] imm_ext,
  output logic              valid_out,
  output logic              prefix_pending
);
  localparam int PRE_W = DATA_W - SHORT_W;

  localparam logic [2:0] SRC_DP     = 3'b000;
  localparam logic [2:0] SRC_MEM    = 3'b001;
  localparam logic [2:0] SRC_BR     = 3'b010;
  localparam logic [2:0] SRC_DP_S   = 3'b011;
  localparam logic [2:0] SRC_BR_S   = 3'b100;

  if (PRE_W < 1 || PRE_W > IMM_W || IMM_W > DATA_W) begin : g_bad_params
    $error("imm_ext_unit: need 1 <= DATA_W-SHORT_W <= IMM_W <= DATA_W");
  end

  logic [SHORT_W-1:0] short_imm;
  logic [DATA_W-1:0]  ext_norm;
  logic [DATA_W-1:0]  ext_next;

  assign short_imm = imm[SHORT_W-1:0];

  always_comb begin
    ext_norm = '0;
    case (imm_src)
      SRC_DP, SRC_MEM: ext_norm = DATA_W'(short_imm);
      SRC_BR:          ext_norm = DATA_W'(imm);
      SRC_DP_S:        ext_norm = DATA_W'($signed(short_imm));
      SRC_BR_S:        ext_norm = DATA_W'($signed(imm));
      default:         ext_norm = '0;
    endcase
  end

`ifdef IMM_EXT_PREFIX_EN
  logic [PRE_W-1:0] prefix_reg;
  logic             use_prefix;

  // Only the short-immediate modes splice in the prefix; branches discard it.
  assign use_prefix = prefix_pending &&
                      (imm_src == SRC_DP || imm_src == SRC_MEM || imm_src == SRC_DP_S);

  always_comb begin
    ext_next = ext_norm;
    if (prefix_load)     ext_next = '0;
    else if (use_prefix) ext_next = {prefix_reg, short_imm};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prefix_reg     <= '0;
      prefix_pending <= 1'b0;
    end else if (flush) begin
      prefix_pending <= 1'b0;
    end else if (!stall && valid_in) begin
      if (prefix_load) begin
        prefix_reg     <= imm[PRE_W-1:0];
        prefix_pending <= 1'b1;
      end else begin
        prefix_pending <= 1'b0;
      end
    end
  end
`else
  logic unused_prefix_load;

  assign unused_prefix_load = prefix_load;
  assign ext_next           = ext_norm;
  assign prefix_pending     = 1'b0;
`endif

  // imm_ext keeps its last value on idle cycles; only valid_out drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_ext   <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      imm_ext   <= '0;
      valid_out <= 1'b0;
    end else if (!stall) begin
      valid_out <= valid_in;
      if (valid_in) imm_ext <= ext_next;
    end
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Randomized and directed bench for imm_ext_unit against an arithmetic reference model.
module tb_imm_ext_unit;
`ifdef IMM_EXT_PREFIX_EN
  localparam bit PFX = 1'b1;
`else
  localparam bit PFX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [18:0] imm = '0;
  logic [2:0]  imm_src = '0;
  logic        prefix_load = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [21:0] imm_ext;
  logic        valid_out;
  logic        prefix_pending;

  int checks = 0;
  int errors = 0;

  int unsigned m_ext = 0;
  int unsigned m_pre = 0;
  bit          m_vld = 1'b0;
  bit          m_pend = 1'b0;

  imm_ext_unit dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .imm(imm), .imm_src(imm_src),
    .prefix_load(prefix_load), .stall(stall), .flush(flush),
    .imm_ext(imm_ext), .valid_out(valid_out), .prefix_pending(prefix_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: extension computed from the mode rules with plain integer arithmetic mod 2^22.
  function automatic int unsigned model_ext(input int unsigned src, input int unsigned im, input bit pend);
    int unsigned s;
    s = im % 128;
    case (src)
      0, 1: return pend ? m_pre * 128 + s : s;
      3:    return pend ? m_pre * 128 + s : (s >= 64 ? s + (1 << 22) - 128 : s);
      2:    return im;
      4:    return im >= (1 << 18) ? im + (1 << 22) - (1 << 19) : im;
      default: return 0;
    endcase
  endfunction

  task automatic step(input bit rst, input bit v, input bit pl, input bit st, input bit fl,
                      input int unsigned src, input int unsigned im);
    reset = rst; valid_in = v; prefix_load = pl; stall = st; flush = fl;
    imm_src = src[2:0]; imm = im[18:0];
    @(posedge clk);
    if (rst) begin
      m_ext = 0; m_vld = 0; m_pend = 0; m_pre = 0;
    end else if (fl) begin
      m_ext = 0; m_vld = 0; m_pend = 0;
    end else if (!st) begin
      m_vld = v;
      if (v) begin
        if (pl && PFX) begin
          m_pre = im % (1 << 15); m_pend = 1; m_ext = 0;
        end else begin
          m_ext = model_ext(src, im % (1 << 19), m_pend);
          m_pend = 0;
        end
      end
    end
    #1;
    chk("ext", 32'(imm_ext), m_ext);
    chk("vld", 32'(valid_out), 32'(m_vld));
    chk("pend", 32'(prefix_pending), 32'(m_pend));
  endtask

  task automatic issue(input bit pl, input int unsigned src, input int unsigned im);
    step(0, 1, pl, 0, 0, src, im);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 19'h7FFFF);
    chk("rst_ext", 32'(imm_ext), 0);
    chk("rst_vld", 32'(valid_out), 0);

    // extension modes
    issue(0, 3, 19'h0007F); chk("sx_dp", 32'(imm_ext), 32'h3FFFFF); chk("sx_dp_v", 32'(valid_out), 1);
    issue(0, 0, 19'h0007F); chk("zx_dp", 32'(imm_ext), 32'h00007F);
    issue(0, 4, 19'h40000); chk("sx_br", 32'(imm_ext), 32'h3C0000);
    issue(0, 2, 19'h40000); chk("zx_br", 32'(imm_ext), 32'h040000);
    issue(0, 5, 19'h7FFFF); chk("rsv", 32'(imm_ext), 0);
    issue(0, 1, 19'h7FFC3); chk("zx_mem", 32'(imm_ext), 32'h000043);

    // prefix consume, then no prefix
    issue(1, 0, 19'h01234);
    chk("pfx_pend", 32'(prefix_pending), 32'(PFX));
    issue(0, 0, 19'h00055); chk("pfx_use", 32'(imm_ext), PFX ? 32'h091A55 : 32'h000055);
    chk("pfx_clr", 32'(prefix_pending), 0);
    issue(0, 0, 19'h00055); chk("pfx_gone", 32'(imm_ext), 32'h000055);

    // branch discards prefix
    issue(1, 0, 19'h07FFF);
    issue(0, 2, 19'h00010); chk("pfx_br", 32'(imm_ext), 32'h000010);
    chk("pfx_br_clr", 32'(prefix_pending), 0);

    // stall holds everything
    issue(1, 0, 19'h00ABC);
    for (int i = 0; i < 3; i++) step(0, i[0], 0, 1, 0, 3, $urandom & 32'h7FFFF);
    chk("stall_pend", 32'(prefix_pending), 32'(PFX));
    issue(0, 2, 19'h00321); chk("stall_rel", 32'(imm_ext), 32'h000321);

    // flush and reset kill a pending prefix and the in-flight instruction
    issue(1, 0, 19'h01234);
    step(0, 1, 0, 0, 1, 0, 19'h00055);
    chk("fl_ext", 32'(imm_ext), 0); chk("fl_vld", 32'(valid_out), 0);
    issue(0, 0, 19'h00055); chk("fl_re", 32'(imm_ext), 32'h000055);
    issue(1, 0, 19'h01234);
    step(1, 1, 0, 0, 0, 0, 19'h00055);
    chk("rs_pend", 32'(prefix_pending), 0);
    issue(0, 0, 19'h00055); chk("rs_re", 32'(imm_ext), 32'h000055);

    // PREFIX with mode 000: NOP when enabled, normal extension when not
    issue(1, 0, 19'h00055); chk("pl_mode", 32'(imm_ext), PFX ? 32'h0 : 32'h000055);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 7), $urandom & 32'h7FFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
